// File: rtl/irq_controller.sv
// irq_controller: edge-detects NSRC device interrupt lines into a pending
// register, requests the lowest-numbered pending and unmasked source on
// ExtIRQ, and retires it when the processor acknowledges on ExtlAck.
module irq_controller #(
  parameter int NSRC    = 4,
  parameter int IDW     = 2,
  parameter int HOLDOFF = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [NSRC-1:0] mask,
  input  logic            ExtlAck,
  output logic            ExtIRQ,
  output logic [IDW-1:0]  irq_id,
  output logic [NSRC-1:0] pending,
  output logic [7:0]      lost_count
);

  // Holdoff counter must hold HOLDOFF itself; keep at least one bit for HOLDOFF=0/1.
  localparam int HCW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] src_prev_q, src_prev_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [HCW-1:0]  hold_q, hold_d;
  logic [IDW-1:0]  irq_id_q, irq_id_d;
  logic            ext_irq_q, ext_irq_d;
  logic [7:0]      lost_q, lost_d;

  logic [NSRC-1:0] edge_s;
  logic [NSRC-1:0] clr_s;
  logic [NSRC-1:0] lost_bits_s;
  logic [NSRC-1:0] eligible_s;
  logic [4:0]      lost_inc_s;
  logic [8:0]      lost_sum_s;

  // Lowest set index of a vector; returns 0 for an all-zero vector.
  function automatic logic [IDW-1:0] lowest_idx(input logic [NSRC-1:0] v);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Edge detection, retire strobes and pending/lost-edge bookkeeping.
  always_comb begin
    src_prev_d  = src;
    edge_s      = src & ~src_prev_q;
    eligible_s  = pending_q & mask;
    clr_s       = '0;
    lost_inc_s  = 5'd0;
    for (int i = 0; i < NSRC; i++) begin
      clr_s[i] = (state_q == REQ) && ExtlAck && (irq_id_q == IDW'(i));
    end
    // An edge coinciding with its own retire keeps the bit pending and is not lost.
    lost_bits_s = edge_s & pending_q & ~clr_s;
    pending_d   = (pending_q & ~clr_s) | edge_s;
    for (int i = 0; i < NSRC; i++) begin
      if (lost_bits_s[i]) begin
        lost_inc_s = lost_inc_s + 5'd1;
      end else begin
        lost_inc_s = lost_inc_s;
      end
    end
    lost_sum_s = {1'b0, lost_q} + {4'b0000, lost_inc_s};
    if (lost_sum_s > 9'd255) begin
      lost_d = 8'hFF;
    end else begin
      lost_d = lost_sum_s[7:0];
    end
  end

  // Request FSM: select in IDLE, hold request in REQ, wait for ack release in DONE.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    irq_id_d = irq_id_q;
    case (state_q)
      IDLE: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HCW'(1);
        end else if (eligible_s != '0) begin
          irq_id_d = lowest_idx(eligible_s);
          state_d  = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (ExtlAck) begin
          state_d = DONE;
        end else begin
          state_d = REQ;
        end
      end
      DONE: begin
        if (!ExtlAck) begin
          hold_d  = HCW'(HOLDOFF);
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ext_irq_d = (state_d == REQ);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      src_prev_q <= '0;
      pending_q  <= '0;
      hold_q     <= '0;
      irq_id_q   <= '0;
      ext_irq_q  <= 1'b0;
      lost_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      src_prev_q <= src_prev_d;
      pending_q  <= pending_d;
      hold_q     <= hold_d;
      irq_id_q   <= irq_id_d;
      ext_irq_q  <= ext_irq_d;
      lost_q     <= lost_d;
    end
  end

  assign ExtIRQ     = ext_irq_q;
  assign irq_id     = irq_id_q;
  assign pending    = pending_q;
  assign lost_count = lost_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller (NSRC=4, IDW=2, HOLDOFF=4).
module tb_irq_controller;

  localparam int NSRC    = 4;
  localparam int IDW     = 2;
  localparam int HOLDOFF = 4;

  logic            clk;
  logic            reset;
  logic [NSRC-1:0] src;
  logic [NSRC-1:0] mask;
  logic            ExtlAck;
  logic            ExtIRQ;
  logic [IDW-1:0]  irq_id;
  logic [NSRC-1:0] pending;
  logic [7:0]      lost_count;

  int n_cmp = 0;
  int n_err = 0;
  int ncyc;

  irq_controller #(.NSRC(NSRC), .IDW(IDW), .HOLDOFF(HOLDOFF)) dut (
    .clk        (clk),
    .reset      (reset),
    .src        (src),
    .mask       (mask),
    .ExtlAck    (ExtlAck),
    .ExtIRQ     (ExtIRQ),
    .irq_id     (irq_id),
    .pending    (pending),
    .lost_count (lost_count)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count clocks until ExtIRQ rises, bounded at 20.
  task automatic wait_irq(output int n);
    n = 0;
    while (n < 20 && ExtIRQ !== 1'b1) begin
      step();
      n++;
    end
  endtask

  initial begin
    reset   = 1'b1;
    src     = 4'b0000;
    mask    = 4'b1111;
    ExtlAck = 1'b0;

    // Reset state
    step();
    step();
    check_val("rst_irq",     {31'd0, ExtIRQ}, 32'd0);
    check_val("rst_id",      {30'd0, irq_id}, 32'd0);
    check_val("rst_pending", {28'd0, pending}, 32'd0);
    check_val("rst_lost",    {24'd0, lost_count}, 32'd0);
    reset = 1'b0;
    step();

    // 1: single source, latency and retire
    src = 4'b0100;
    step();
    check_val("t1_pending", {28'd0, pending}, 32'h4);
    check_val("t1_irq_early", {31'd0, ExtIRQ}, 32'd0);
    step();
    check_val("t1_irq", {31'd0, ExtIRQ}, 32'd1);
    check_val("t1_id",  {30'd0, irq_id}, 32'd2);
    ExtlAck = 1'b1;
    step();
    check_val("t1_irq_ack",     {31'd0, ExtIRQ}, 32'd0);
    check_val("t1_pending_ack", {28'd0, pending}, 32'd0);
    ExtlAck = 1'b0;
    src     = 4'b0000;
    step();
    repeat (6) step();

    // 2: simultaneous sources served lowest first, holdoff spacing
    src = 4'b1010;
    step();
    check_val("t2_pending", {28'd0, pending}, 32'hA);
    step();
    check_val("t2_irq1", {31'd0, ExtIRQ}, 32'd1);
    check_val("t2_id1",  {30'd0, irq_id}, 32'd1);
    ExtlAck = 1'b1;
    step();
    check_val("t2_pending_ack1", {28'd0, pending}, 32'h8);
    ExtlAck = 1'b0;
    wait_irq(ncyc);
    check_val("t2_gap", ncyc, HOLDOFF + 2);
    check_val("t2_id2", {30'd0, irq_id}, 32'd3);
    ExtlAck = 1'b1;
    step();
    check_val("t2_pending_ack2", {28'd0, pending}, 32'd0);
    ExtlAck = 1'b0;
    src     = 4'b0000;
    step();
    repeat (5) step();

    // 3: masked source recorded but not requested until unmasked
    mask = 4'b1110;
    src  = 4'b0001;
    step();
    check_val("t3_pending", {28'd0, pending}, 32'h1);
    step();
    step();
    check_val("t3_masked_irq", {31'd0, ExtIRQ}, 32'd0);
    mask = 4'b1111;
    step();
    step();
    check_val("t3_irq", {31'd0, ExtIRQ}, 32'd1);
    check_val("t3_id",  {30'd0, irq_id}, 32'd0);
    ExtlAck = 1'b1;
    step();
    ExtlAck = 1'b0;
    mask    = 4'b1110;
    src     = 4'b0000;
    step();

    // 4: lost edges on an already-pending source, saturation
    for (int p = 0; p < 3; p++) begin
      src = 4'b0001;
      step();
      src = 4'b0000;
      step();
    end
    check_val("t4_lost2", {24'd0, lost_count}, 32'd2);
    for (int p = 0; p < 300; p++) begin
      src = 4'b0001;
      step();
      src = 4'b0000;
      step();
    end
    check_val("t4_lost_sat", {24'd0, lost_count}, 32'd255);
    check_val("t4_pending",  {28'd0, pending}, 32'h1);
    check_val("t4_irq",      {31'd0, ExtIRQ}, 32'd0);

    // 5: new edge on the served source in the ack cycle
    reset = 1'b1;
    mask  = 4'b1111;
    step();
    check_val("t5_rst_lost", {24'd0, lost_count}, 32'd0);
    reset = 1'b0;
    step();
    src = 4'b0001;
    step();
    step();
    check_val("t5_irq", {31'd0, ExtIRQ}, 32'd1);
    src = 4'b0000;
    step();
    src     = 4'b0001;
    ExtlAck = 1'b1;
    step();
    check_val("t5_pending_kept", {28'd0, pending}, 32'h1);
    check_val("t5_lost",         {24'd0, lost_count}, 32'd0);
    check_val("t5_irq_ack",      {31'd0, ExtIRQ}, 32'd0);
    ExtlAck = 1'b0;
    wait_irq(ncyc);
    check_val("t5_gap", ncyc, HOLDOFF + 2);
    check_val("t5_id",  {30'd0, irq_id}, 32'd0);

    // 6: reset mid-handshake, ack held after reset
    src = 4'b0000;
    step();
    src = 4'b0001;
    step();
    check_val("t6_lost_pre", {24'd0, lost_count}, 32'd1);
    check_val("t6_irq_pre",  {31'd0, ExtIRQ}, 32'd1);
    reset   = 1'b1;
    ExtlAck = 1'b1;
    src     = 4'b0000;
    step();
    check_val("t6_irq",     {31'd0, ExtIRQ}, 32'd0);
    check_val("t6_pending", {28'd0, pending}, 32'd0);
    check_val("t6_lost",    {24'd0, lost_count}, 32'd0);
    reset = 1'b0;
    repeat (4) step();
    check_val("t6_hold_irq",     {31'd0, ExtIRQ}, 32'd0);
    check_val("t6_hold_pending", {28'd0, pending}, 32'd0);
    check_val("t6_hold_id",      {30'd0, irq_id}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
